// File: rtl/bit_interleave_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : bit_interleave_stage
// Purpose  : Streaming Keccak lane (de)interleaver in front of / behind the
//            32-bit bit-interleaved rotate datapath.
//            Interleave   : even lane bits -> low word, odd bits -> high word.
//            Deinterleave : the inverse mapping.
//            Registered valid/ready stage with a 2-entry output FIFO and a
//            lane counter that tags every lane with its index in the state.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            flush      - synchronous clear of FIFO, lane counter, par_err
//            in_valid   - input lane valid
//            in_ready   - stage accepts a lane this cycle (registered)
//            in_mode    - 0 = interleave, 1 = deinterleave (per lane)
//            in_lane    - input lane [W-1:0]
//            out_valid  - output lane valid
//            out_ready  - downstream accepts the lane
//            out_lane   - transformed lane [W-1:0]
//            out_idx    - lane index 0..LANES-1 of out_lane
//            out_last   - out_idx == LANES-1
//            in_par     - expected parity of in_lane     (parity build only)
//            out_par    - XOR-reduction of out_lane      (parity build only)
//            par_err    - sticky input parity error      (parity build only)
// Config   : `define BIT_INTERLEAVE_PARITY_EN to add the parity ports/logic.
// Params   : LANES - lanes per permutation state (default 25)
//            W     - lane width, fixed at 64
// Revision : 1.0 - initial release
// ============================================================================
module bit_interleave_stage #(
    parameter int LANES = 25,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [W-1:0] in_lane,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_lane,
    output logic [4:0]   out_idx,
    output logic         out_last
`ifdef BIT_INTERLEAVE_PARITY_EN
    ,
    input  logic         in_par,
    output logic         out_par,
    output logic         par_err
`endif
);

    localparam logic [4:0] c_LAST_IDX = 5'(LANES - 1);

    // ------------------------------------------------------------------------
    // Lane transform (pure wiring)
    // ------------------------------------------------------------------------
    logic [W-1:0] w_il;
    logic [W-1:0] w_dl;
    logic [W-1:0] w_xf;

    for (genvar k = 0; k < 32; k++) begin : g_bits
        assign w_il[k]       = in_lane[2*k];
        assign w_il[32+k]    = in_lane[2*k+1];
        assign w_dl[2*k]     = in_lane[k];
        assign w_dl[2*k+1]   = in_lane[32+k];
    end

    assign w_xf = in_mode ? w_dl : w_il;

    // ------------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------------
    logic [1:0] r_count;
    logic       r_in_ready;
    logic [4:0] r_lane_cnt;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;
    logic [1:0] w_fill;
    logic       w_wr_tail;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && out_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Occupancy left after this cycle's pop decides the slot the new lane
    // lands in: nothing left -> head, head still occupied -> tail.
    assign w_fill    = r_count - {1'b0, w_pop};
    assign w_wr_tail = (w_fill != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
            r_lane_cnt <= 5'd0;
        end else if (flush) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_lane_cnt <= 5'd0;
        end else begin
            r_count    <= w_count_nxt;
            // Ready is a pure register of the next occupancy, so out_ready
            // never reaches in_ready combinationally.
            r_in_ready <= (w_count_nxt != 2'd2);
            if (w_push) begin
                r_lane_cnt <= (r_lane_cnt == c_LAST_IDX) ? 5'd0 : r_lane_cnt + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry FIFO: head drives the outputs, tail shifts into head on pop
    // ------------------------------------------------------------------------
    logic [W-1:0] r_head_lane;
    logic [4:0]   r_head_idx;
    logic [W-1:0] r_tail_lane;
    logic [4:0]   r_tail_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_lane <= '0;
            r_head_idx  <= 5'd0;
            r_tail_lane <= '0;
            r_tail_idx  <= 5'd0;
        end else if (!flush) begin
            if (w_pop) begin
                r_head_lane <= r_tail_lane;
                r_head_idx  <= r_tail_idx;
            end
            if (w_push) begin
                if (w_wr_tail) begin
                    r_tail_lane <= w_xf;
                    r_tail_idx  <= r_lane_cnt;
                end else begin
                    r_head_lane <= w_xf;
                    r_head_idx  <= r_lane_cnt;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_lane  = r_head_lane;
    assign out_idx   = r_head_idx;
    assign out_last  = (r_head_idx == c_LAST_IDX);

`ifdef BIT_INTERLEAVE_PARITY_EN
    // ------------------------------------------------------------------------
    // Parity: the transform is a bit permutation, so the parity of the
    // transformed lane equals the parity of the input lane.
    // ------------------------------------------------------------------------
    logic w_lane_par;
    logic r_head_par;
    logic r_tail_par;
    logic r_par_err;

    assign w_lane_par = ^in_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_par <= 1'b0;
            r_tail_par <= 1'b0;
            r_par_err  <= 1'b0;
        end else if (flush) begin
            r_par_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head_par <= r_tail_par;
            end
            if (w_push) begin
                if (w_wr_tail) begin
                    r_tail_par <= w_lane_par;
                end else begin
                    r_head_par <= w_lane_par;
                end
                if (w_lane_par != in_par) begin
                    r_par_err <= 1'b1;
                end
            end
        end
    end

    assign out_par = r_head_par;
    assign par_err = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_interleave_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_bit_interleave_stage
// Purpose  : Self-checking bench for bit_interleave_stage: directed vector
//            table, backpressure / lane-index / flush / reset sequences, a
//            random-traffic phase and a rotate round trip, all checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_interleave_stage;

    localparam int LANES = 25;
    localparam int RT_N  = 10000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [63:0] in_lane;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_lane;
    logic [4:0]  out_idx;
    logic        out_last;
`ifdef BIT_INTERLEAVE_PARITY_EN
    logic        in_par;
    logic        out_par;
    logic        par_err;
    logic        bad_par;
    logic        mperr;
`endif

    bit_interleave_stage #(.LANES(LANES), .W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_lane   (in_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef BIT_INTERLEAVE_PARITY_EN
        ,
        .in_par    (in_par),
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [63:0] lane;
        int          idx;
        logic        par;
    } ent_t;

    ent_t        mq[$];
    int          mcnt = 0;
    logic        mon_en = 1'b0;
    logic [63:0] cap_lane[$];
    int          cap_idx[$];
    logic        cap_last[$];

    // Bit i of the lane goes to word (i mod 2), position i/2 of that word.
    function automatic logic [63:0] ref_il(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[(i % 2) * 32 + i / 2] = x[i];
        return r;
    endfunction

    function automatic logic [63:0] ref_dl(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[i] = x[(i % 2) * 32 + i / 2];
        return r;
    endfunction

    function automatic logic [63:0] ref_xf(input logic m, input logic [63:0] x);
        return m ? ref_dl(x) : ref_il(x);
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int s);
        logic [63:0] t;
        t = {x, x} >> (s % 32);
        return t[31:0];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int s);
        logic [127:0] t;
        t = {x, x} >> s;
        return t[63:0];
    endfunction

    // ROTR64 by amt expressed on the interleaved {odd, even} word pair.
    function automatic logic [63:0] il_rotr(input logic [63:0] w, input int amt);
        logic [31:0] ev, od;
        int m;
        ev = w[31:0];
        od = w[63:32];
        m  = amt / 2;
        if (amt % 2 == 0) return {rotr32(od, m), rotr32(ev, m)};
        else              return {rotr32(ev, m + 1), rotr32(od, m)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
    endtask

    // Scoreboard: sampled on the falling edge, half a cycle from any input
    // change and from the active edge.
    always @(negedge clk) begin
        int   sz;
        ent_t h;
        ent_t e;
        if (mon_en) begin
            sz = mq.size();
            chk("out_valid", out_valid, sz != 0);
            chk("in_ready", in_ready, sz < 2);
`ifdef BIT_INTERLEAVE_PARITY_EN
            chk("par_err", par_err, mperr);
`endif
            if (sz != 0) begin
                h = mq[0];
                chk("out_lane", out_lane, h.lane);
                chk("out_idx", out_idx, h.idx);
                chk("out_last", out_last, h.idx == LANES - 1);
`ifdef BIT_INTERLEAVE_PARITY_EN
                chk("out_par", out_par, h.par);
`endif
            end
            if (flush) begin
                mq.delete();
                mcnt = 0;
`ifdef BIT_INTERLEAVE_PARITY_EN
                mperr = 1'b0;
`endif
            end else begin
                if (sz != 0 && out_ready) begin
                    cap_lane.push_back(out_lane);
                    cap_idx.push_back(int'(out_idx));
                    cap_last.push_back(out_last);
                    void'(mq.pop_front());
                end
                if (in_valid && sz < 2) begin
                    e.lane = ref_xf(in_mode, in_lane);
                    e.idx  = mcnt;
                    e.par  = ^e.lane;
                    mq.push_back(e);
                    mcnt = (mcnt + 1) % LANES;
`ifdef BIT_INTERLEAVE_PARITY_EN
                    if ((^in_lane) != in_par) mperr = 1'b1;
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drivers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic set_in(input logic m, input logic [63:0] l);
        in_mode = m;
        in_lane = l;
`ifdef BIT_INTERLEAVE_PARITY_EN
        in_par  = (^l) ^ bad_par;
`endif
    endtask

    task automatic send(input logic m, input logic [63:0] l);
        int budget;
        budget = 200;
        set_in(m, l);
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) timeout("send");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        out_ready = 1'b1;
        while (out_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) timeout("drain");
    endtask

    task automatic flush_now();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic clear_caps();
        cap_lane.delete();
        cap_idx.delete();
        cap_last.delete();
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------------
    typedef struct {
        logic        mode;
        logic [63:0] lane;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] src[RT_N];
    logic [63:0] mid[RT_N];

    initial begin
        int n;
        int lasts;
        logic [63:0] a, b, c;

        vecs[0] = '{1'b0, 64'h0000_0000_0000_0002, 64'h0000_0001_0000_0000};
        vecs[1] = '{1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{1'b1, 64'hFFFF_FFFF_0000_0000, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[3] = '{1'b1, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005};
        vecs[4] = '{1'b0, 64'h5555_5555_5555_5555, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{1'b1, 64'h0000_0000_FFFF_FFFF, 64'h5555_5555_5555_5555};
        vecs[6] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[7] = '{1'b0, 64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000};
        vecs[8] = '{1'b1, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0002};
        vecs[9] = '{1'b0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef BIT_INTERLEAVE_PARITY_EN
        bad_par   = 1'b0;
        mperr     = 1'b0;
`endif
        set_in(1'b0, 64'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        mon_en = 1'b1;

        // Vector table: one lane at a time, result one cycle after the push
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].mode, vecs[i].lane);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_lane", i), out_lane, vecs[i].exp);
            chk($sformatf("vec%0d_idx", i), out_idx, i);
            chk($sformatf("vec%0d_last", i), out_last, 0);
            @(posedge clk); #1;
        end

        // Backpressure: two lanes fill the buffer, the third waits
        clear_caps();
        out_ready = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        send(1'b0, a);
        send(1'b0, b);
        chk("bp_full_in_ready", in_ready, 0);
        set_in(1'b0, c);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_in_ready", in_ready, 0);
        chk("bp_hold_lane", out_lane, ref_il(a));
        out_ready = 1'b1;
        send(1'b0, c);
        drain();
        chk("bp_count", cap_lane.size(), 3);
        if (cap_lane.size() == 3) begin
            chk("bp_order0", cap_lane[0], ref_il(a));
            chk("bp_order1", cap_lane[1], ref_il(b));
            chk("bp_order2", cap_lane[2], ref_il(c));
        end

        // 26-lane stream: last flag on index 24 only, then wrap to 0
        flush_now();
        clear_caps();
        for (int i = 0; i < 26; i++) send(i[0], {$urandom, $urandom});
        drain();
        chk("t5_count", cap_idx.size(), 26);
        if (cap_idx.size() == 26) begin
            lasts = 0;
            foreach (cap_last[i]) if (cap_last[i]) lasts++;
            chk("t5_num_last", lasts, 1);
            chk("t5_idx24", cap_idx[24], 24);
            chk("t5_last24", cap_last[24], 1);
            chk("t5_idx25", cap_idx[25], 0);
            chk("t5_last25", cap_last[25], 0);
        end

        // Flush mid-state, colliding with a push and a pop
        for (int i = 0; i < 5; i++) send(1'b1, {$urandom, $urandom});
        set_in(1'b0, {$urandom, $urandom});
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        a = {$urandom, $urandom};
        send(1'b0, a);
        chk("flush_next_valid", out_valid, 1);
        chk("flush_next_idx", out_idx, 0);
        chk("flush_next_lane", out_lane, ref_il(a));
        drain();

        // Asynchronous reset with two lanes buffered
        out_ready = 1'b0;
        send(1'b0, {$urandom, $urandom});
        send(1'b1, {$urandom, $urandom});
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_idx", out_idx, 0);
        mq.delete();
        mcnt = 0;
`ifdef BIT_INTERLEAVE_PARITY_EN
        mperr = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_in_ready", in_ready, 1);
        chk("arst_rel_out_valid", out_valid, 0);
        mon_en    = 1'b1;
        out_ready = 1'b1;
        a = {$urandom, $urandom};
        send(1'b0, a);
        chk("arst_next_idx", out_idx, 0);
        chk("arst_next_lane", out_lane, ref_il(a));
        drain();

`ifdef BIT_INTERLEAVE_PARITY_EN
        // Sticky parity error, cleared only by flush
        flush_now();
        bad_par = 1'b1;
        send(1'b0, {$urandom, $urandom});
        bad_par = 1'b0;
        chk("par_err_set", par_err, 1);
        send(1'b1, {$urandom, $urandom});
        repeat (4) @(posedge clk);
        #1;
        chk("par_err_held", par_err, 1);
        flush_now();
        chk("par_err_clr", par_err, 0);
`endif

        // Random traffic with backpressure, mixed modes and rare flushes
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
`ifdef BIT_INTERLEAVE_PARITY_EN
            bad_par   = ($urandom_range(0, 15) == 0);
`endif
            set_in(1'($urandom_range(0, 1)), {$urandom, $urandom});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
`ifdef BIT_INTERLEAVE_PARITY_EN
        bad_par  = 1'b0;
`endif
        drain();

        // Round trip: interleave, rotate in the interleaved domain, deinterleave
        flush_now();
        clear_caps();
        for (int i = 0; i < RT_N; i++) begin
            src[i] = {$urandom, $urandom};
            send(1'b0, src[i]);
        end
        drain();
        chk("rt_count_il", cap_lane.size(), RT_N);
        n = (cap_lane.size() < RT_N) ? cap_lane.size() : RT_N;
        for (int i = 0; i < n; i++) mid[i] = il_rotr(cap_lane[i], i % 64);
        clear_caps();
        for (int i = 0; i < n; i++) send(1'b1, mid[i]);
        drain();
        chk("rt_count_dl", cap_lane.size(), n);
        for (int i = 0; i < n && i < cap_lane.size(); i++)
            chk($sformatf("rt_lane%0d_amt%0d", i, i % 64), cap_lane[i], rotr64(src[i], i % 64));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
